// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants and types for the VGA raster generator.
//   - Default 640x480 @ 60 Hz timing values (pixel clock = system clock / 4).
//   - Derived line/frame totals and sync window bounds.
//   - coord_t: 10-bit raster coordinate.
package vga_pkg;

  localparam int unsigned DEF_CLK_DIV   = 4;
  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;

  localparam int unsigned H_TOTAL = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  typedef logic [9:0] coord_t;

  // Inclusive window test used for the sync pulses.
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/horizontal_counter.sv
// horizontal_counter: pixel position within a line.
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   enable   - advance by one (driven by the pixel tick)
//   pixel_x  - current horizontal count, 0..H_TOTAL-1
//   done_x   - high while pixel_x is the last position of the line
module horizontal_counter
  import vga_pkg::coord_t;
#(
  parameter int unsigned H_TOTAL = 800
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   enable,
  output coord_t pixel_x,
  output logic   done_x
);

  localparam coord_t Last = coord_t'(H_TOTAL - 1);

  coord_t r_cnt;

  assign done_x  = (r_cnt == Last);
  assign pixel_x = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= done_x ? '0 : r_cnt + coord_t'(1);
    end
  end

endmodule

// File: rtl/vertical_counter.sv
// vertical_counter: line position within a frame.
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   enable   - advance by one (once per line)
//   pixel_y  - current vertical count, 0..V_TOTAL-1
//   done_y   - high while pixel_y is the last line of the frame
module vertical_counter
  import vga_pkg::coord_t;
#(
  parameter int unsigned V_TOTAL = 525
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   enable,
  output coord_t pixel_y,
  output logic   done_y
);

  localparam coord_t Last = coord_t'(V_TOTAL - 1);

  coord_t r_cnt;

  assign done_y  = (r_cnt == Last);
  assign pixel_y = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= done_y ? '0 : r_cnt + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing from the system clock.
//   clk         - system clock (single clock domain)
//   reset_n     - asynchronous active-low reset
//   enable      - run; low freezes divider, counters and outputs
//   pixel_tick  - combinational, high in the clk whose end advances the counters
//   pixel_x/y   - registered raster position
//   hsync_n     - registered horizontal sync, active low
//   vsync_n     - registered vertical sync, active low
//   video_on    - registered, high inside the visible area
//   line_start  - registered one-clk pulse when pixel_x first shows 0
//   frame_start - registered one-clk pulse when (0,0) is first shown
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   enable,
  output logic   pixel_tick,
  output coord_t pixel_x,
  output coord_t pixel_y,
  output logic   hsync_n,
  output logic   vsync_n,
  output logic   video_on,
  output logic   line_start,
  output logic   frame_start
);

  localparam int unsigned HTotal = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned DivW   = $clog2(CLK_DIV);

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  localparam coord_t HDisp      = coord_t'(H_DISPLAY);
  localparam coord_t VDisp      = coord_t'(V_DISPLAY);
  localparam coord_t HSyncStart = coord_t'(H_DISPLAY + H_FP);
  localparam coord_t HSyncEnd   = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam coord_t VSyncStart = coord_t'(V_DISPLAY + V_FP);
  localparam coord_t VSyncEnd   = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);

  // The vertical stage is a fixed 525-line counter.
  if (V_DISPLAY + V_FP + V_SYNC + V_BP != V_TOTAL) begin : g_bad_v_total
    $error("vga_timing_gen: vertical parameters must sum to %0d", V_TOTAL);
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end
  if (HTotal > 1024) begin : g_bad_h_total
    $error("vga_timing_gen: horizontal total does not fit a 10-bit coordinate");
  end

  // Pixel-rate divider
  logic [DivW-1:0] r_div_cnt;
  logic            w_pixel_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
    end else if (enable) begin
      r_div_cnt <= (r_div_cnt == DivLast) ? '0 : r_div_cnt + DivW'(1);
    end
  end

  assign w_pixel_tick = enable && (r_div_cnt == DivLast);
  assign pixel_tick   = w_pixel_tick;

  // Counters
  coord_t w_h_cnt;
  coord_t w_v_cnt;
  logic   w_done_x;
  logic   w_done_y;
  logic   w_line_adv;

  assign w_line_adv = w_pixel_tick && w_done_x;

  horizontal_counter #(
    .H_TOTAL(HTotal)
  ) u_h_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (w_pixel_tick),
    .pixel_x(w_h_cnt),
    .done_x (w_done_x)
  );

  vertical_counter #(
    .V_TOTAL(V_TOTAL)
  ) u_v_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (w_line_adv),
    .pixel_y(w_v_cnt),
    .done_y (w_done_y)
  );

  // Output register stage
  // The wrap flags add one clk so the pulses land in the same clk where the
  // registered pixel_x first shows 0, keeping every output mutually aligned.
  coord_t r_pixel_x;
  coord_t r_pixel_y;
  logic   r_hsync_n;
  logic   r_vsync_n;
  logic   r_video_on;
  logic   r_line_wrap;
  logic   r_frame_wrap;
  logic   r_line_start;
  logic   r_frame_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_video_on    <= 1'b0;
      r_line_wrap   <= 1'b0;
      r_frame_wrap  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (enable) begin
      r_pixel_x     <= w_h_cnt;
      r_pixel_y     <= w_v_cnt;
      r_hsync_n     <= !in_window(w_h_cnt, HSyncStart, HSyncEnd);
      r_vsync_n     <= !in_window(w_v_cnt, VSyncStart, VSyncEnd);
      r_video_on    <= (w_h_cnt < HDisp) && (w_v_cnt < VDisp);
      r_line_wrap   <= w_line_adv;
      r_frame_wrap  <= w_line_adv && w_done_y;
      r_line_start  <= r_line_wrap;
      r_frame_start <= r_frame_wrap;
    end
  end

  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign hsync_n     = r_hsync_n;
  assign vsync_n     = r_vsync_n;
  assign video_on    = r_video_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Two instances share one clock: the default
// 640x480 timing (line-level checks) and a narrow-line build (CLK_DIV=2,
// 16-pixel lines) so a whole 525-line frame fits in a short run.
// Stimulus pushes hand-computed expected output vectors tagged with the
// clk count at which they must appear; a monitor pops and compares them.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance
  logic   d_rst_n = 1'b0;
  logic   d_en = 1'b0;
  logic   d_tick, d_hs, d_vs, d_vo, d_ls, d_fs;
  coord_t d_px, d_py;

  vga_timing_gen u_dut (
    .clk        (clk),
    .reset_n    (d_rst_n),
    .enable     (d_en),
    .pixel_tick (d_tick),
    .pixel_x    (d_px),
    .pixel_y    (d_py),
    .hsync_n    (d_hs),
    .vsync_n    (d_vs),
    .video_on   (d_vo),
    .line_start (d_ls),
    .frame_start(d_fs)
  );

  // Narrow-line instance: 8 visible, sync on h 10..13, 16 per line
  logic   s_rst_n = 1'b0;
  logic   s_en = 1'b0;
  logic   s_tick, s_hs, s_vs, s_vo, s_ls, s_fs;
  coord_t s_px, s_py;

  vga_timing_gen #(
    .CLK_DIV  (2),
    .H_DISPLAY(8),
    .H_FP     (2),
    .H_SYNC   (4),
    .H_BP     (2)
  ) u_small (
    .clk        (clk),
    .reset_n    (s_rst_n),
    .enable     (s_en),
    .pixel_tick (s_tick),
    .pixel_x    (s_px),
    .pixel_y    (s_py),
    .hsync_n    (s_hs),
    .vsync_n    (s_vs),
    .video_on   (s_vo),
    .line_start (s_ls),
    .frame_start(s_fs)
  );

  typedef struct {
    int unsigned cyc;
    bit          sel;
    string       name;
    int          px;
    int          py;
    bit          tk, hs, vs, vo, ls, fs;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic push(input int unsigned dly, input bit sel, input string name,
                      input int px, input int py, input bit tk, input bit hs,
                      input bit vs, input bit vo, input bit ls, input bit fs);
    exp_t e;
    e.cyc = cyc + dly; e.sel = sel; e.name = name; e.px = px; e.py = py;
    e.tk = tk; e.hs = hs; e.vs = vs; e.vo = vo; e.ls = ls; e.fs = fs;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: compare every entry due at this sample point.
  initial begin : monitor
    exp_t e;
    int   a_px, a_py;
    bit   a_tk, a_hs, a_vs, a_vo, a_ls, a_fs;
    forever begin
      @(negedge clk);
      while (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_checks++;
        if (e.sel) begin
          a_px = int'(s_px); a_py = int'(s_py); a_tk = s_tick; a_hs = s_hs;
          a_vs = s_vs; a_vo = s_vo; a_ls = s_ls; a_fs = s_fs;
        end else begin
          a_px = int'(d_px); a_py = int'(d_py); a_tk = d_tick; a_hs = d_hs;
          a_vs = d_vs; a_vo = d_vo; a_ls = d_ls; a_fs = d_fs;
        end
        if (e.cyc != cyc) begin
          $display("FAIL %s: sample point %0d passed unchecked (now %0d)", e.name, e.cyc, cyc);
        end else if (a_px == e.px && a_py == e.py && a_tk == e.tk && a_hs == e.hs &&
                     a_vs == e.vs && a_vo == e.vo && a_ls == e.ls && a_fs == e.fs) begin
          n_pass++;
        end else begin
          $display("FAIL %s @%0d: got x=%0d y=%0d tick=%b hs=%b vs=%b vo=%b ls=%b fs=%b, want x=%0d y=%0d tick=%b hs=%b vs=%b vo=%b ls=%b fs=%b",
                   e.name, cyc, a_px, a_py, a_tk, a_hs, a_vs, a_vo, a_ls, a_fs,
                   e.px, e.py, e.tk, e.hs, e.vs, e.vo, e.ls, e.fs);
        end
      end
    end
  end

  // Startup sequence of the default instance after reset release, enable high.
  task automatic push_start_d(input string tag);
    push(1, 0, {tag, "_first_sample"}, 0, 0, 0, 1, 1, 1, 0, 0);
    push(3, 0, {tag, "_first_tick"},   0, 0, 1, 1, 1, 1, 0, 0);
    push(4, 0, {tag, "_h_adv"},        0, 0, 0, 1, 1, 1, 0, 0);
    push(5, 0, {tag, "_px_one"},       1, 0, 0, 1, 1, 1, 0, 0);
  endtask

  int unsigned c;
  int unsigned p;
  int unsigned s;

  initial begin : stim
    repeat (2) @(negedge clk);
    push(1, 0, "reset_default", 0, 0, 0, 1, 1, 0, 0, 0);
    push(1, 1, "reset_small",   0, 0, 0, 1, 1, 0, 0, 0);
    wait_cyc(cyc + 2);

    // Release default instance; c = last clk before counting starts.
    d_rst_n = 1'b1;
    d_en    = 1'b1;
    c = cyc;
    push_start_d("start");
    push(2560,  0, "video_last",   639, 0, 0, 1, 1, 1, 0, 0);
    push(2561,  0, "video_off",    640, 0, 0, 1, 1, 0, 0, 0);
    push(2624,  0, "hs_before",    655, 0, 0, 1, 1, 0, 0, 0);
    push(2625,  0, "hs_fall",      656, 0, 0, 0, 1, 0, 0, 0);
    push(3008,  0, "hs_last_low",  751, 0, 0, 0, 1, 0, 0, 0);
    push(3009,  0, "hs_rise",      752, 0, 0, 1, 1, 0, 0, 0);
    push(3200,  0, "line0_end",    799, 0, 0, 1, 1, 0, 0, 0);
    push(3201,  0, "line1_start",  0,   1, 0, 1, 1, 1, 1, 0);
    push(35199, 0, "line10_tick",  799, 10, 1, 1, 1, 0, 0, 0);
    push(35200, 0, "line10_end",   799, 10, 0, 1, 1, 0, 0, 0);
    push(35201, 0, "line11_start", 0,   11, 0, 1, 1, 1, 1, 0);

    // Pause at h_cnt=300 with div_cnt=2, for 50 clks.
    wait_cyc(c + 36402);
    d_en = 1'b0;
    p = cyc;
    push(1,  0, "pause_hold_a",   300, 11, 0, 1, 1, 1, 0, 0);
    push(28, 0, "pause_hold_b",   300, 11, 0, 1, 1, 1, 0, 0);
    push(50, 0, "pause_hold_c",   300, 11, 0, 1, 1, 1, 0, 0);
    push(51, 0, "resume_tick",    300, 11, 1, 1, 1, 1, 0, 0);
    push(52, 0, "resume_h_adv",   300, 11, 0, 1, 1, 1, 0, 0);
    push(53, 0, "resume_px301",   301, 11, 0, 1, 1, 1, 0, 0);
    wait_cyc(p + 50);
    d_en = 1'b1;

    // Asynchronous reset in the middle of hsync (h_cnt=700, line 11).
    wait_cyc(c + 38050);
    push(1, 0, "pre_reset_hsync", 700, 11, 0, 0, 1, 0, 0, 0);
    wait_cyc(c + 38051);
    @(posedge clk);
    #1 d_rst_n = 1'b0;
    push(0, 0, "async_reset", 0, 0, 0, 1, 1, 0, 0, 0);
    wait_cyc(cyc + 2);
    d_rst_n = 1'b1;
    c = cyc;
    push_start_d("restart");
    wait_cyc(c + 6);

    // Narrow-line instance: full frames.
    s_rst_n = 1'b1;
    s_en    = 1'b1;
    s = cyc;
    push(1,     1, "s_first_sample", 0,  0,   1, 1, 1, 1, 0, 0);
    push(2,     1, "s_h_adv",        0,  0,   0, 1, 1, 1, 0, 0);
    push(3,     1, "s_px_one",       1,  0,   1, 1, 1, 1, 0, 0);
    push(21,    1, "s_hs_fall",      10, 0,   1, 0, 1, 0, 0, 0);
    push(28,    1, "s_hs_last_low",  13, 0,   0, 0, 1, 0, 0, 0);
    push(29,    1, "s_hs_rise",      14, 0,   1, 1, 1, 0, 0, 0);
    push(15680, 1, "s_vs_before",    15, 489, 0, 1, 1, 0, 0, 0);
    push(15681, 1, "s_vs_fall",      0,  490, 1, 1, 0, 0, 1, 0);
    push(15744, 1, "s_vs_last_low",  15, 491, 0, 1, 0, 0, 0, 0);
    push(15745, 1, "s_vs_rise",      0,  492, 1, 1, 1, 0, 1, 0);
    push(16799, 1, "s_wrap_tick",    15, 524, 1, 1, 1, 0, 0, 0);
    push(16800, 1, "s_frame_end",    15, 524, 0, 1, 1, 0, 0, 0);
    push(16801, 1, "s_frame_start",  0,  0,   1, 1, 1, 1, 1, 1);
    push(16802, 1, "s_pulse_end",    0,  0,   0, 1, 1, 1, 0, 0);
    push(33600, 1, "s_frame2_end",   15, 524, 0, 1, 1, 0, 0, 0);
    push(33601, 1, "s_frame2_start", 0,  0,   1, 1, 1, 1, 1, 1);
    wait_cyc(s + 33605);

    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      $display("FAIL %s: sample point %0d never reached", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
